// File: rtl/alu_pkg.sv
// ALU op codes, port ids and slot state shared by the ALU arbiter slice.
// Provides is_legal_op() used to flag unsupported op codes.
package alu_pkg;

   localparam int ALU_OP_W = 4;

   localparam logic [ALU_OP_W-1:0] OP_AND = 4'b0000;
   localparam logic [ALU_OP_W-1:0] OP_OR  = 4'b0001;
   localparam logic [ALU_OP_W-1:0] OP_ADD = 4'b0010;
   localparam logic [ALU_OP_W-1:0] OP_SUB = 4'b0110;
   localparam logic [ALU_OP_W-1:0] OP_NOR = 4'b1100;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

   function automatic logic is_legal_op(
      input logic [ALU_OP_W-1:0] op
   );
      return (op == OP_AND) || (op == OP_OR) ||
             (op == OP_ADD) || (op == OP_SUB) ||
             (op == OP_NOR);
   endfunction

endpackage

// File: rtl/ALU_64_bit.sv
// Combinational ALU: AND/OR/ADD/SUB/NOR, wrapping arithmetic.
// Ports: a, b, alu_op in; result, zero out. Unknown ops give 0.
module ALU_64_bit
   import alu_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int OP_W  = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OP_W-1:0]  alu_op,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   always_comb begin
      result = '0;
      case (alu_op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_NOR:  result = ~(a | b);
         default: result = '0;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin grant with its own pointer register.
// Ports: clk, reset_n, valid0/1, fire in; grant, grant_vld out.
module alu_rr_arb2
   import alu_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic valid0,
   input  logic valid1,
   input  logic fire,
   output logic grant,
   output logic grant_vld
);

   logic rr_ptr;

   // Pointer only matters under contention; a lone
   // requester wins regardless of where it points.
   assign grant_vld = valid0 | valid1;
   assign grant     = (valid0 & valid1) ? rr_ptr : valid1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_ptr <= PORT0;
      end else if (fire) begin
         rr_ptr <= ~grant;
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters with a one-entry result slot.
// Ports: req0/1 (valid/ready/a/b/op), rsp0/1 (valid/ready/result/zero/err), grant_cnt0/1.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int OP_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OP_W-1:0]  req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OP_W-1:0]  req1_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   output logic             rsp0_zero,
   output logic             rsp0_err,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic             rsp1_zero,
   output logic             rsp1_err,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1
);

   slot_state_t      state, state_nxt;
   logic             owner;
   logic [WIDTH-1:0] slot_result;
   logic             slot_zero;
   logic             slot_err;

   logic             grant, grant_vld;
   logic             owner_ready;
   logic             can_accept;
   logic             fire;
   logic [WIDTH-1:0] mux_a, mux_b, alu_result;
   logic [OP_W-1:0]  mux_op;
   logic             alu_zero;

   alu_rr_arb2 u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .valid0    (req0_valid),
      .valid1    (req1_valid),
      .fire      (fire),
      .grant     (grant),
      .grant_vld (grant_vld)
   );

   assign mux_a  = grant ? req1_a  : req0_a;
   assign mux_b  = grant ? req1_b  : req0_b;
   assign mux_op = grant ? req1_op : req0_op;

   ALU_64_bit #(
      .WIDTH (WIDTH),
      .OP_W  (OP_W)
   ) u_alu (
      .a      (mux_a),
      .b      (mux_b),
      .alu_op (mux_op),
      .result (alu_result),
      .zero   (alu_zero)
   );

   // Draining and refilling in the same cycle keeps one op per clock.
   assign owner_ready = owner ? rsp1_ready : rsp0_ready;
   assign can_accept  = (state == EMPTY) |
                        ((state == FULL) & owner_ready);
   assign fire        = can_accept & grant_vld;

   assign req0_ready = fire & (grant == PORT0);
   assign req1_ready = fire & (grant == PORT1);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: begin
            if (fire) state_nxt = FULL;
         end
         FULL: begin
            if (fire)             state_nxt = FULL;
            else if (owner_ready) state_nxt = EMPTY;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         owner       <= PORT0;
         slot_result <= '0;
         slot_zero   <= 1'b0;
         slot_err    <= 1'b0;
      end else if (fire) begin
         owner       <= grant;
         slot_result <= alu_result;
         slot_zero   <= alu_zero;
         slot_err    <= ~is_legal_op(mux_op);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (fire) begin
         if (grant == PORT0 && !(&grant_cnt0))
            grant_cnt0 <= grant_cnt0 + CNT_W'(1);
         if (grant == PORT1 && !(&grant_cnt1))
            grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      end
   end

   assign rsp0_valid  = (state == FULL) & (owner == PORT0);
   assign rsp1_valid  = (state == FULL) & (owner == PORT1);
   assign rsp0_result = slot_result;
   assign rsp1_result = slot_result;
   assign rsp0_zero   = slot_zero;
   assign rsp1_zero   = slot_zero;
   assign rsp0_err    = slot_err;
   assign rsp1_err    = slot_err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table,
// directed corner sequences and a randomized reference model.
module tb_alu_share_arbiter;

   localparam int W  = 64;
   localparam int OW = 4;
   localparam int CW = 8;
   localparam logic [CW-1:0] CMAX = '1;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          req0_valid, req1_valid;
   logic          req0_ready, req1_ready;
   logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic [OW-1:0] req0_op, req1_op;
   logic          rsp0_valid, rsp1_valid;
   logic          rsp0_ready, rsp1_ready;
   logic [W-1:0]  rsp0_result, rsp1_result;
   logic          rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
   logic [CW-1:0] grant_cnt0, grant_cnt1;

   always #5 clk = ~clk;

   alu_share_arbiter #(
      .WIDTH (W),
      .OP_W  (OW),
      .CNT_W (CW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_op     (req0_op),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_op     (req1_op),
      .rsp0_valid  (rsp0_valid),
      .rsp0_ready  (rsp0_ready),
      .rsp0_result (rsp0_result),
      .rsp0_zero   (rsp0_zero),
      .rsp0_err    (rsp0_err),
      .rsp1_valid  (rsp1_valid),
      .rsp1_ready  (rsp1_ready),
      .rsp1_result (rsp1_result),
      .rsp1_zero   (rsp1_zero),
      .rsp1_err    (rsp1_err),
      .grant_cnt0  (grant_cnt0),
      .grant_cnt1  (grant_cnt1)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req0_valid = 0; req1_valid = 0;
      req0_a = '0; req0_b = '0; req0_op = '0;
      req1_a = '0; req1_b = '0; req1_op = '0;
      rsp0_ready = 1; rsp1_ready = 1;
   endtask

   task automatic do_reset();
      reset_n = 0;
      idle();
      cyc();
      cyc();
      reset_n = 1;
   endtask

   task automatic drive(input bit p, input logic [OW-1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      if (!p) begin
         req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   // Reference ALU, straight from the op table.
   function automatic logic [W-1:0] ref_alu(input logic [OW-1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b1100: return ~(a | b);
         default: return '0;
      endcase
   endfunction

   function automatic bit ref_err(input logic [OW-1:0] op);
      return !(op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100});
   endfunction

   typedef struct {
      bit            port;
      logic [OW-1:0] op;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [W-1:0]  res;
      bit            zero;
      bit            err;
   } vec_t;

   vec_t vt[9];

   // Random-phase model state
   bit           m_full;
   bit           m_owner;
   bit           m_last;
   logic [W-1:0] m_res;
   bit           m_zero, m_err;
   int           m_cnt[2];

   initial begin
      logic [W-1:0] ones;
      ones = '1;

      vt[0] = '{0, 4'b0010, 64'd5, 64'd7, 64'd12, 0, 0};
      vt[1] = '{0, 4'b0110, 64'd9, 64'd9, 64'd0, 1, 0};
      vt[2] = '{1, 4'b1100, 64'd0, 64'd0, ones, 0, 0};
      vt[3] = '{0, 4'b0000, 64'hF0F0, 64'h0FF0, 64'h00F0, 0, 0};
      vt[4] = '{1, 4'b0001, 64'h0F00, 64'h00F0, 64'h0FF0, 0, 0};
      vt[5] = '{1, 4'b0111, 64'd3, 64'd4, 64'd0, 1, 1};
      vt[6] = '{0, 4'b0110, 64'd0, 64'd1, ones, 0, 0};
      vt[7] = '{0, 4'b0010, ones, 64'd1, 64'd0, 1, 0};
      vt[8] = '{1, 4'b1111, ones, ones, 64'd0, 1, 1};

      // Reset state and first ready
      do_reset();
      chk("rst_rsp0_valid", W'(rsp0_valid), 0);
      chk("rst_rsp1_valid", W'(rsp1_valid), 0);
      chk("rst_cnt0", W'(grant_cnt0), 0);
      chk("rst_cnt1", W'(grant_cnt1), 0);
      drive(0, 4'b0010, 64'd5, 64'd7);
      #1;
      chk("rst_req0_ready", W'(req0_ready), 1);
      chk("rst_req1_ready", W'(req1_ready), 0);
      cyc();
      idle();
      #1;
      chk("single_rsp0_valid", W'(rsp0_valid), 1);
      chk("single_rsp1_valid", W'(rsp1_valid), 0);
      chk("single_result", rsp0_result, 64'd12);
      chk("single_zero", W'(rsp0_zero), 0);
      chk("single_err", W'(rsp0_err), 0);
      chk("single_cnt0", W'(grant_cnt0), 1);
      cyc();
      chk("drain_rsp0_valid", W'(rsp0_valid), 0);

      // Vector table, one op per cycle
      foreach (vt[i]) begin
         drive(vt[i].port, vt[i].op, vt[i].a, vt[i].b);
         #1;
         chk($sformatf("vt%0d_ready", i),
             W'(vt[i].port ? req1_ready : req0_ready), 1);
         cyc();
         req0_valid = 0; req1_valid = 0;
         #1;
         chk($sformatf("vt%0d_valid", i),
             W'(vt[i].port ? rsp1_valid : rsp0_valid), 1);
         chk($sformatf("vt%0d_other", i),
             W'(vt[i].port ? rsp0_valid : rsp1_valid), 0);
         chk($sformatf("vt%0d_result", i),
             vt[i].port ? rsp1_result : rsp0_result, vt[i].res);
         chk($sformatf("vt%0d_zero", i),
             W'(vt[i].port ? rsp1_zero : rsp0_zero), W'(vt[i].zero));
         chk($sformatf("vt%0d_err", i),
             W'(vt[i].port ? rsp1_err : rsp0_err), W'(vt[i].err));
      end
      cyc();

      // Contention alternates 0,1,0,1
      do_reset();
      drive(0, 4'b0110, 64'd9, 64'd9);
      drive(1, 4'b1100, 64'd0, 64'd0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("cont%0d_r0", i), W'(req0_ready), W'(i % 2 == 0));
         chk($sformatf("cont%0d_r1", i), W'(req1_ready), W'(i % 2 == 1));
         cyc();
         if (i % 2 == 0) begin
            chk($sformatf("cont%0d_v0", i), W'(rsp0_valid), 1);
            chk($sformatf("cont%0d_res0", i), rsp0_result, 64'd0);
            chk($sformatf("cont%0d_z0", i), W'(rsp0_zero), 1);
         end else begin
            chk($sformatf("cont%0d_v1", i), W'(rsp1_valid), 1);
            chk($sformatf("cont%0d_res1", i), rsp1_result, ones);
         end
      end
      idle();
      cyc();

      // Backpressure on port 0, pending port 1
      rsp0_ready = 0;
      drive(0, 4'b0010, 64'd5, 64'd7);
      cyc();
      req0_valid = 0;
      drive(1, 4'b0001, 64'd1, 64'd2);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp%0d_v0", i), W'(rsp0_valid), 1);
         chk($sformatf("bp%0d_res", i), rsp0_result, 64'd12);
         chk($sformatf("bp%0d_r1", i), W'(req1_ready), 0);
         cyc();
      end
      rsp0_ready = 1;
      #1;
      chk("bp_release_r1", W'(req1_ready), 1);
      cyc();
      req1_valid = 0;
      #1;
      chk("bp_v0_after", W'(rsp0_valid), 0);
      chk("bp_v1_after", W'(rsp1_valid), 1);
      chk("bp_res1", rsp1_result, 64'd3);
      cyc();

      // Saturation of port-1 counter
      do_reset();
      drive(1, 4'b0010, 64'd1, 64'd1);
      for (int i = 0; i < int'(CMAX) + 20; i++) cyc();
      idle();
      #1;
      chk("sat_cnt1", W'(grant_cnt1), W'(CMAX));
      chk("sat_cnt0", W'(grant_cnt0), 0);
      cyc();

      // Reset while FULL discards the slot
      rsp0_ready = 0;
      drive(0, 4'b0110, 64'd0, 64'd1);
      cyc();
      req0_valid = 0;
      chk("rf_full_v0", W'(rsp0_valid), 1);
      chk("rf_wrap", rsp0_result, ones);
      reset_n = 0;
      cyc();
      reset_n = 1;
      #1;
      chk("rf_v0", W'(rsp0_valid), 0);
      chk("rf_v1", W'(rsp1_valid), 0);
      chk("rf_cnt0", W'(grant_cnt0), 0);
      cyc();
      chk("rf_v0_later", W'(rsp0_valid), 0);

      // Randomized run against the reference model
      do_reset();
      m_full = 0; m_owner = 0; m_last = 1;
      m_res = '0; m_zero = 0; m_err = 0;
      m_cnt[0] = 0; m_cnt[1] = 0;
      for (int c = 0; c < 3000; c++) begin
         bit v[2], rr[2], avail, drain, win;
         logic [OW-1:0] op[2];
         logic [W-1:0] a[2], b[2];
         logic [OW-1:0] legal[5];
         legal = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100};
         for (int p = 0; p < 2; p++) begin
            v[p]  = ($urandom_range(0, 9) < 6);
            rr[p] = ($urandom_range(0, 9) < 7);
            op[p] = ($urandom_range(0, 9) < 8) ?
                    legal[$urandom_range(0, 4)] : OW'($urandom);
            a[p]  = {$urandom, $urandom};
            b[p]  = ($urandom_range(0, 3) == 0) ? a[p] : {$urandom, $urandom};
         end
         req0_valid = v[0]; req0_op = op[0]; req0_a = a[0]; req0_b = b[0];
         req1_valid = v[1]; req1_op = op[1]; req1_a = a[1]; req1_b = b[1];
         rsp0_ready = rr[0]; rsp1_ready = rr[1];
         #1;
         drain = m_full && rr[m_owner];
         avail = !m_full || drain;
         win   = (v[0] && v[1]) ? !m_last : v[1];
         chk("rnd_r0", W'(req0_ready), W'(avail && v[0] && win == 0));
         chk("rnd_r1", W'(req1_ready), W'(avail && v[1] && win == 1));
         chk("rnd_v0", W'(rsp0_valid), W'(m_full && m_owner == 0));
         chk("rnd_v1", W'(rsp1_valid), W'(m_full && m_owner == 1));
         chk("rnd_cnt0", W'(grant_cnt0), W'(m_cnt[0]));
         chk("rnd_cnt1", W'(grant_cnt1), W'(m_cnt[1]));
         if (m_full) begin
            chk("rnd_res", m_owner ? rsp1_result : rsp0_result, m_res);
            chk("rnd_zero", W'(m_owner ? rsp1_zero : rsp0_zero), W'(m_zero));
            chk("rnd_err", W'(m_owner ? rsp1_err : rsp0_err), W'(m_err));
         end
         if (avail && (v[0] || v[1])) begin
            m_full  = 1;
            m_owner = win;
            m_last  = win;
            m_res   = ref_alu(op[win], a[win], b[win]);
            m_zero  = (m_res == '0);
            m_err   = ref_err(op[win]);
            if (m_cnt[win] < int'(CMAX)) m_cnt[win]++;
         end else if (drain) begin
            m_full = 0;
         end
         cyc();
      end

      idle();
      cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
